ppu_vram_port: RTL and testbench

//  PPU-side memory port directly downstream of the PPU register interface. Takes the

---
 rtl/ppu_vram_port_if.sv | 21 ++
 rtl/ppu_vram_port.sv | 156 +++++++++++++++
 tb/tb_ppu_vram_port.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_vram_port_if.sv
// Register-interface side of the PPU memory port: one $2007 access in flight per request.
// Requests are 1-cycle pulses; ri_busy_out high means further pulses are dropped.
interface ppu_vram_port_if;
    logic [13:0] ri_addr_in;
    logic [7:0]  ri_d_in;
    logic        ri_wr_req_in;
    logic        ri_rd_req_in;
    logic [7:0]  ri_d_out;
    logic        ri_ack_out;
    logic        ri_busy_out;

    modport master (
        output ri_addr_in, ri_d_in, ri_wr_req_in, ri_rd_req_in,
        input  ri_d_out, ri_ack_out, ri_busy_out
    );

    modport slave (
        input  ri_addr_in, ri_d_in, ri_wr_req_in, ri_rd_req_in,
        output ri_d_out, ri_ack_out, ri_busy_out
    );
endinterface

// File: rtl/ppu_vram_port.sv
// PPU memory port: decodes $2007 accesses to CHR / mirrored NT / palette; write ack 2 clk, read MEM_LAT+2.
// Renderer fetches own the external port; a pending register access waits (busy) until it is free.
module ppu_vram_port #(
    parameter bit MIRROR_V     = 1'b1,
    parameter int MEM_LAT      = 1,
    parameter bit CHR_WRITABLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_in,
    ppu_vram_port_if.slave        ri,
    input  logic                  rnd_req_in,
    input  logic [13:0]           rnd_addr_in,
    output logic [7:0]            rnd_d_out,
    output logic                  rnd_vld_out,
    input  logic [4:0]            pal_idx_in,
    output logic [5:0]            pal_d_out,
    output logic [12:0]           chr_a_out,
    input  logic [7:0]            chr_d_in,
    output logic [7:0]            chr_d_out,
    output logic                  chr_we_out,
    output logic [10:0]           nt_a_out,
    input  logic [7:0]            nt_d_in,
    output logic [7:0]            nt_d_out,
    output logic                  nt_we_out
);

    typedef enum logic [2:0] {S_IDLE, S_PEND, S_ISSUE, S_WAITD, S_PAL, S_ACK} state_t;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_RND  = 2'd1;
    localparam logic [1:0] TAG_RI   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       nt;
    } tag_t;

    function automatic logic [4:0] pal_fold(input logic [4:0] idx);
        return (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
    endfunction

    function automatic logic [10:0] nt_map(input logic [13:0] a);
        return {(MIRROR_V ? a[10] : a[11]), a[9:0]};
    endfunction

    state_t      r_state, w_next;
    logic [13:0] r_buf_a;
    logic [7:0]  r_buf_d;
    logic        r_buf_wr;
    logic [7:0]  r_d_out;
    logic [5:0]  r_pal [32];
    logic [5:0]  r_pal_d;
    tag_t        r_pipe [MEM_LAT];
    logic [12:0] r_chr_a;
    logic [10:0] r_nt_a;

    logic        w_rnd_go, w_busy, w_capture, w_buf_pal, w_buf_nt;
    logic [4:0]  w_pal_idx;
    tag_t        w_push, w_tail;
    logic [7:0]  w_tail_d;

    // Reset gates the renderer so every output reads 0 while rst_in is low.
    assign w_rnd_go  = rnd_req_in & rst_in;
    assign w_busy    = (r_state == S_PEND) || (r_state == S_ISSUE) ||
                       (r_state == S_WAITD) || (r_state == S_PAL);
    assign w_capture = ~w_busy & (ri.ri_wr_req_in | ri.ri_rd_req_in);
    assign w_buf_pal = (r_buf_a[13:8] == 6'h3F);
    assign w_buf_nt  = r_buf_a[13] & ~w_buf_pal;
    assign w_pal_idx = pal_fold(r_buf_a[4:0]);
    assign w_tail    = r_pipe[MEM_LAT-1];
    assign w_tail_d  = w_tail.nt ? nt_d_in : chr_d_in;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_capture) w_next = S_PEND;
            S_PEND:  if (w_buf_pal) w_next = S_PAL;
                     else if (!w_rnd_go) w_next = S_ISSUE;
            // A renderer fetch landing on the issue cycle takes the port; retry from PEND.
            S_ISSUE: if (w_rnd_go) w_next = S_PEND;
                     else if (r_buf_wr) w_next = S_ACK;
                     else w_next = S_WAITD;
            S_WAITD: if (w_tail.kind == TAG_RI) w_next = S_ACK;
            S_PAL:   w_next = S_ACK;
            S_ACK:   w_next = w_capture ? S_PEND : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        chr_a_out  = r_chr_a;
        nt_a_out   = r_nt_a;
        chr_we_out = 1'b0;
        nt_we_out  = 1'b0;
        w_push     = '{kind: TAG_NONE, nt: 1'b0};
        if (w_rnd_go) begin
            w_push = '{kind: TAG_RND, nt: rnd_addr_in[13]};
            if (rnd_addr_in[13]) nt_a_out  = nt_map(rnd_addr_in);
            else                 chr_a_out = rnd_addr_in[12:0];
        end else if (r_state == S_ISSUE) begin
            if (w_buf_nt) begin
                nt_a_out  = nt_map(r_buf_a);
                nt_we_out = r_buf_wr;
            end else begin
                chr_a_out  = r_buf_a[12:0];
                chr_we_out = r_buf_wr & CHR_WRITABLE;
            end
            if (!r_buf_wr) w_push = '{kind: TAG_RI, nt: w_buf_nt};
        end
    end

    assign chr_d_out      = r_buf_d;
    assign nt_d_out       = r_buf_d;
    assign rnd_vld_out    = (w_tail.kind == TAG_RND);
    assign rnd_d_out      = rnd_vld_out ? w_tail_d : 8'h00;
    assign pal_d_out      = r_pal_d;
    assign ri.ri_d_out    = r_d_out;
    assign ri.ri_ack_out  = (r_state == S_ACK);
    assign ri.ri_busy_out = w_busy;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_buf_a  <= '0;
            r_buf_d  <= '0;
            r_buf_wr <= 1'b0;
            r_d_out  <= '0;
            r_pal_d  <= '0;
            r_chr_a  <= '0;
            r_nt_a   <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
            for (int i = 0; i < 32; i++)      r_pal[i]  <= '0;
        end else begin
            r_chr_a   <= chr_a_out;
            r_nt_a    <= nt_a_out;
            r_pipe[0] <= w_push;
            for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            r_pal_d   <= r_pal[pal_fold(pal_idx_in)];
            if (w_capture) begin
                r_buf_a  <= ri.ri_addr_in;
                r_buf_d  <= ri.ri_d_in;
                r_buf_wr <= ri.ri_wr_req_in;
            end
            if ((r_state == S_WAITD) && (w_tail.kind == TAG_RI)) r_d_out <= w_tail_d;
            if (r_state == S_PAL) begin
                if (r_buf_wr) r_pal[w_pal_idx] <= r_buf_d[5:0];
                else          r_d_out <= {2'b00, r_pal[w_pal_idx]};
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench: two port instances (A: vertical mirror, MEM_LAT=2, CHR ROM; B: horizontal, MEM_LAT=1, CHR RAM).
// Both see identical stimulus; each is backed by its own behavioural synchronous memories.
module tb_ppu_vram_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] addr;
    logic [7:0]  wd;
    logic        wr, rd, rnd_req;
    logic [13:0] rnd_addr;
    logic [4:0]  pal_idx;

    int passed = 0, total = 0, failed = 0;
    int la, lb;
    int ack_a, ack_b, vld_a, vld_b, good_a, good_b, chrwe_a, chrwe_b;

    ppu_vram_port_if ifa();
    ppu_vram_port_if ifb();

    assign ifa.ri_addr_in = addr;  assign ifb.ri_addr_in = addr;
    assign ifa.ri_d_in    = wd;    assign ifb.ri_d_in    = wd;
    assign ifa.ri_wr_req_in = wr;  assign ifb.ri_wr_req_in = wr;
    assign ifa.ri_rd_req_in = rd;  assign ifb.ri_rd_req_in = rd;

    logic [7:0]  a_rnd_d, b_rnd_d, a_chr_di, b_chr_di, a_chr_do, b_chr_do;
    logic [7:0]  a_nt_di, b_nt_di, a_nt_do, b_nt_do;
    logic        a_rnd_vld, b_rnd_vld, a_chr_we, b_chr_we, a_nt_we, b_nt_we;
    logic [5:0]  a_pal_d, b_pal_d;
    logic [12:0] a_chr_a, b_chr_a;
    logic [10:0] a_nt_a, b_nt_a;

    ppu_vram_port #(.MIRROR_V(1'b1), .MEM_LAT(2), .CHR_WRITABLE(1'b0)) dut_a (
        .clk(clk), .rst_in(rst_n), .ri(ifa),
        .rnd_req_in(rnd_req), .rnd_addr_in(rnd_addr), .rnd_d_out(a_rnd_d), .rnd_vld_out(a_rnd_vld),
        .pal_idx_in(pal_idx), .pal_d_out(a_pal_d),
        .chr_a_out(a_chr_a), .chr_d_in(a_chr_di), .chr_d_out(a_chr_do), .chr_we_out(a_chr_we),
        .nt_a_out(a_nt_a), .nt_d_in(a_nt_di), .nt_d_out(a_nt_do), .nt_we_out(a_nt_we));

    ppu_vram_port #(.MIRROR_V(1'b0), .MEM_LAT(1), .CHR_WRITABLE(1'b1)) dut_b (
        .clk(clk), .rst_in(rst_n), .ri(ifb),
        .rnd_req_in(rnd_req), .rnd_addr_in(rnd_addr), .rnd_d_out(b_rnd_d), .rnd_vld_out(b_rnd_vld),
        .pal_idx_in(pal_idx), .pal_d_out(b_pal_d),
        .chr_a_out(b_chr_a), .chr_d_in(b_chr_di), .chr_d_out(b_chr_do), .chr_we_out(b_chr_we),
        .nt_a_out(b_nt_a), .nt_d_in(b_nt_di), .nt_d_out(b_nt_do), .nt_we_out(b_nt_we));

    // Behavioural memories: A has two read stages, B has one.
    logic [7:0] chr_a_mem [8192];
    logic [7:0] chr_b_mem [8192];
    logic [7:0] nt_a_mem  [2048];
    logic [7:0] nt_b_mem  [2048];
    logic [7:0] a_chr_q1, a_chr_q2, a_nt_q1, a_nt_q2, b_chr_q1, b_nt_q1;

    always @(posedge clk) begin
        if (a_chr_we) chr_a_mem[a_chr_a] <= a_chr_do;
        if (a_nt_we)  nt_a_mem[a_nt_a]   <= a_nt_do;
        if (b_chr_we) chr_b_mem[b_chr_a] <= b_chr_do;
        if (b_nt_we)  nt_b_mem[b_nt_a]   <= b_nt_do;
        a_chr_q1 <= chr_a_mem[a_chr_a];
        a_chr_q2 <= a_chr_q1;
        a_nt_q1  <= nt_a_mem[a_nt_a];
        a_nt_q2  <= a_nt_q1;
        b_chr_q1 <= chr_b_mem[b_chr_a];
        b_nt_q1  <= nt_b_mem[b_nt_a];
    end
    assign a_chr_di = a_chr_q2;
    assign a_nt_di  = a_nt_q2;
    assign b_chr_di = b_chr_q1;
    assign b_nt_di  = b_nt_q1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifa.ri_ack_out) ack_a++;
        if (ifb.ri_ack_out) ack_b++;
        if (a_rnd_vld) begin vld_a++; if (a_rnd_d == 8'hC3) good_a++; end
        if (b_rnd_vld) begin vld_b++; if (b_rnd_d == 8'hC3) good_b++; end
        if (a_chr_we) chrwe_a++;
        if (b_chr_we) chrwe_b++;
    end

    logic [79:0] outs_a, outs_b;
    assign outs_a = {13'b0, ifa.ri_d_out, ifa.ri_ack_out, ifa.ri_busy_out, a_rnd_d, a_rnd_vld, a_pal_d,
                     a_chr_a, a_chr_do, a_chr_we, a_nt_a, a_nt_do, a_nt_we};
    assign outs_b = {13'b0, ifb.ri_d_out, ifb.ri_ack_out, ifb.ri_busy_out, b_rnd_d, b_rnd_vld, b_pal_d,
                     b_chr_a, b_chr_do, b_chr_we, b_nt_a, b_nt_do, b_nt_we};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse one request; latency = clock edges from the capture edge to the ack cycle (-1 = no ack).
    task automatic do_req(input logic w, input logic [13:0] a, input logic [7:0] d, input int rnd_cyc,
                          output int lat_a, output int lat_b);
        lat_a = -1;
        lat_b = -1;
        addr = a; wd = d; wr = w; rd = ~w;
        if (rnd_cyc > 0) rnd_req = 1'b1;
        for (int k = 1; k <= 20 && (lat_a < 0 || lat_b < 0); k++) begin
            tick();
            wr = 1'b0; rd = 1'b0;
            if (k == rnd_cyc) rnd_req = 1'b0;
            if (lat_a < 0 && ifa.ri_ack_out) lat_a = k - 1;
            if (lat_b < 0 && ifb.ri_ack_out) lat_b = k - 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr = '0; wd = '0; wr = 1'b0; rd = 1'b0;
        rnd_req = 1'b0; rnd_addr = 14'h0040; pal_idx = '0;
        ack_a = 0; ack_b = 0; vld_a = 0; vld_b = 0; good_a = 0; good_b = 0; chrwe_a = 0; chrwe_b = 0;
        for (int i = 0; i < 8192; i++) begin
            chr_a_mem[i] = 8'(i * 7 + 3);
            chr_b_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 2048; i++) begin
            nt_a_mem[i] = 8'h00;
            nt_b_mem[i] = 8'h00;
        end
        #1;
        chk("reset_outs_a", outs_a, 80'h0);
        chk("reset_outs_b", outs_b, 80'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // NT write $2005 <- $5A, cycle by cycle
        addr = 14'h2005; wd = 8'h5A; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("wr_busy_after_capture", ifa.ri_busy_out, 1);
        chk("wr_no_early_ack", ifa.ri_ack_out, 0);
        tick();
        chk("wr_nt_we_a", a_nt_we, 1);
        chk("wr_nt_a_a", a_nt_a, 11'h005);
        chk("wr_nt_d_a", a_nt_do, 8'h5A);
        chk("wr_nt_we_b", b_nt_we, 1);
        tick();
        chk("wr_ack_a", ifa.ri_ack_out, 1);
        chk("wr_ack_b", ifb.ri_ack_out, 1);
        chk("wr_busy_drop", ifa.ri_busy_out, 0);
        chk("wr_nt_we_off", a_nt_we, 0);
        tick();
        chk("wr_ack_one_cycle", ifa.ri_ack_out, 0);

        // Palette: $3F10 mirrors $3F00
        do_req(1'b1, 14'h3F10, 8'h21, 0, la, lb);
        chk("pal_wr_lat_a", la, 2);
        do_req(1'b0, 14'h3F00, 8'h00, 0, la, lb);
        chk("pal_rd_lat_b", lb, 2);
        chk("pal_rd_a", ifa.ri_d_out, 8'h21);
        chk("pal_rd_b", ifb.ri_d_out, 8'h21);
        chk("pal_lookup_a", a_pal_d, 6'h21);
        do_req(1'b1, 14'h3F00, 8'h15, 0, la, lb);
        chk("pal_same_cycle_old", a_pal_d, 6'h21);
        tick();
        chk("pal_same_cycle_new", b_pal_d, 6'h15);
        do_req(1'b0, 14'h3F10, 8'h00, 0, la, lb);
        chk("pal_rd_mirror_a", ifa.ri_d_out, 8'h15);

        // Renderer holds the port 5 cycles over a CHR read of $0123
        tick();
        vld_a = 0; vld_b = 0; good_a = 0; good_b = 0;
        do_req(1'b0, 14'h0123, 8'h00, 5, la, lb);
        chk("rnd_stall_lat_a", la, 8);
        chk("rnd_stall_lat_b", lb, 7);
        chk("rnd_ri_data_a", ifa.ri_d_out, 8'hF8);
        chk("rnd_ri_data_b", ifb.ri_d_out, 8'hF8);
        chk("rnd_vld_cnt_a", vld_a, 5);
        chk("rnd_vld_cnt_b", vld_b, 5);
        chk("rnd_data_cnt_a", good_a, 5);
        chk("rnd_data_cnt_b", good_b, 5);
        chk("chr_a_hold_a", a_chr_a, 13'h0123);

        // Mirroring
        do_req(1'b1, 14'h2C00, 8'h77, 0, la, lb);
        chk("nt_a_hold_a", a_nt_a, 11'h400);
        chk("nt_a_hold_b", b_nt_a, 11'h400);
        do_req(1'b0, 14'h2800, 8'h00, 0, la, lb);
        chk("mirror_2800_a", ifa.ri_d_out, 8'h00);
        chk("mirror_2800_b", ifb.ri_d_out, 8'h77);
        chk("nt_rd_lat_a", la, 4);
        chk("nt_rd_lat_b", lb, 3);
        do_req(1'b0, 14'h2400, 8'h00, 0, la, lb);
        chk("mirror_2400_a", ifa.ri_d_out, 8'h77);
        chk("mirror_2400_b", ifb.ri_d_out, 8'h00);

        // Second write pulse while busy is dropped
        tick();
        ack_a = 0; ack_b = 0;
        addr = 14'h2010; wd = 8'hAA; wr = 1'b1;
        tick();
        addr = 14'h2011; wd = 8'hBB;
        tick();
        wr = 1'b0;
        repeat (6) tick();
        chk("busy_one_ack_a", ack_a, 1);
        chk("busy_one_ack_b", ack_b, 1);
        do_req(1'b0, 14'h2011, 8'h00, 0, la, lb);
        chk("busy_dropped_a", ifa.ri_d_out, 8'h00);
        do_req(1'b0, 14'h2010, 8'h00, 0, la, lb);
        chk("busy_kept_b", ifb.ri_d_out, 8'hAA);

        // CHR ROM vs CHR RAM write to $0000
        tick();
        chrwe_a = 0; chrwe_b = 0;
        do_req(1'b1, 14'h0000, 8'h99, 0, la, lb);
        chk("chr_rom_ack_a", la, 2);
        tick();
        chk("chr_rom_we_a", chrwe_a, 0);
        chk("chr_ram_we_b", chrwe_b, 1);
        do_req(1'b0, 14'h0000, 8'h00, 0, la, lb);
        chk("chr_rom_rd_a", ifa.ri_d_out, 8'h03);
        chk("chr_ram_rd_b", ifb.ri_d_out, 8'h99);

        // Reset while a read waits for data
        tick();
        ack_a = 0; ack_b = 0;
        addr = 14'h0123; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick(); tick();
        chk("waitd_busy_a", ifa.ri_busy_out, 1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outs_a", outs_a, 80'h0);
        chk("midop_reset_outs_b", outs_b, 80'h0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_ack_after_reset_a", ack_a, 0);
        chk("no_ack_after_reset_b", ack_b, 0);
        chk("pal_cleared_a", a_pal_d, 6'h00);
        do_req(1'b0, 14'h3F10, 8'h00, 0, la, lb);
        chk("pal_cleared_rd_b", ifb.ri_d_out, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
